// File: rtl/led_7seg_capture.sv
// led_7seg_capture: receives a multiplexed 4-digit active-low 7-segment bus.
// It recovers the 12-bit hex value {H,M,L} and the target flag, and publishes
// them only after MATCH_FRAMES identical, glyph-clean frames.
module led_7seg_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MATCH_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  output logic [11:0] data_out,
  output logic        target_out,
  output logic        data_valid,
  output logic        locked,
  output logic        glyph_err
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DWELL   = 2'd3
  } state_t;

  // Maps a segment pattern to {legal, nibble}. The pattern is reordered to
  // {a,b,c,d,e,f,g} so that the literals read left-to-right as segments a..g.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [6:0] r;
    logic [4:0] res;
    r = {seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6]};
    case (r)
      7'b0000001: res = {1'b1, 4'h0};
      7'b1001111: res = {1'b1, 4'h1};
      7'b0010010: res = {1'b1, 4'h2};
      7'b0000110: res = {1'b1, 4'h3};
      7'b1001100: res = {1'b1, 4'h4};
      7'b0100100: res = {1'b1, 4'h5};
      7'b0100000: res = {1'b1, 4'h6};
      7'b0001111: res = {1'b1, 4'h7};
      7'b0000000: res = {1'b1, 4'h8};
      7'b0001100: res = {1'b1, 4'h9};
      7'b0001000: res = {1'b1, 4'hA};
      7'b1100000: res = {1'b1, 4'hB};
      7'b0110001: res = {1'b1, 4'hC};
      7'b1000010: res = {1'b1, 4'hD};
      7'b0110000: res = {1'b1, 4'hE};
      7'b0111000: res = {1'b1, 4'hF};
      default:    res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  logic [6:0]  seg_p0, s_seg, prev_seg;
  logic [3:0]  sel_p0, s_sel, prev_sel;
  state_t      state, state_next;
  logic [7:0]  settle_cnt, settle_cnt_next;
  logic        load_cap;
  logic [6:0]  cap_seg;
  logic [3:0]  cap_sel;
  logic [3:0]  mask;
  logic        frame_bad;
  logic [3:0]  slot_l, slot_m, slot_h;
  logic        slot_t;
  logic [12:0] cand;
  logic [3:0]  match_cnt;
  logic [4:0]  dec;
  logic        sel_onehot, inputs_stable;
  logic [12:0] frame;

  assign sel_onehot    = $onehot(s_sel);
  assign inputs_stable = (s_sel == prev_sel) && (s_seg == prev_seg);
  assign dec           = decode_glyph(cap_seg);
  assign frame         = {slot_h, slot_m, slot_l, slot_t};

  // Two-flop synchronizers for the asynchronous bus, plus previous-cycle copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p0   <= '0;
      s_seg    <= '0;
      prev_seg <= '0;
      sel_p0   <= '0;
      s_sel    <= '0;
      prev_sel <= '0;
    end else begin
      seg_p0   <= seg_in;
      s_seg    <= seg_p0;
      prev_seg <= s_seg;
      sel_p0   <= dig_sel;
      s_sel    <= sel_p0;
      prev_sel <= s_sel;
    end
  end

  // Capture FSM state and settle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WAIT;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // Next-state logic: settle on a stable one-hot digit, capture once per dwell.
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    load_cap        = 1'b0;
    case (state)
      ST_WAIT: begin
        settle_cnt_next = '0;
        if (sel_onehot) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!sel_onehot) begin
          state_next      = ST_WAIT;
          settle_cnt_next = '0;
        end else if (!inputs_stable) begin
          settle_cnt_next = '0;
        end else if (settle_cnt == 8'(SETTLE_CYCLES - 1)) begin
          state_next      = ST_CAPTURE;
          settle_cnt_next = '0;
          load_cap        = 1'b1;
        end else begin
          settle_cnt_next = settle_cnt + 8'd1;
        end
      end
      ST_CAPTURE: begin
        settle_cnt_next = '0;
        state_next      = ST_DWELL;
      end
      ST_DWELL: begin
        settle_cnt_next = '0;
        if (s_sel != cap_sel) state_next = sel_onehot ? ST_SETTLE : ST_WAIT;
      end
      default: begin
        state_next      = ST_WAIT;
        settle_cnt_next = '0;
      end
    endcase
  end

  // Holds the settled digit and pattern that the CAPTURE cycle decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_seg <= '0;
      cap_sel <= '0;
    end else if (load_cap) begin
      cap_seg <= s_seg;
      cap_sel <= s_sel;
    end
  end

  // Digit slots, capture mask, sticky bad flag, candidate and match counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= '0;
      frame_bad <= 1'b0;
      slot_l    <= '0;
      slot_m    <= '0;
      slot_h    <= '0;
      slot_t    <= 1'b0;
      cand      <= '0;
      match_cnt <= '0;
      glyph_err <= 1'b0;
    end else begin
      glyph_err <= (state == ST_CAPTURE) && !dec[4];
      if (mask == 4'hF) begin
        if (frame_bad) begin
          match_cnt <= '0;
        end else if (frame == cand) begin
          if (match_cnt < 4'(MATCH_FRAMES)) match_cnt <= match_cnt + 4'd1;
        end else begin
          cand      <= frame;
          match_cnt <= 4'd1;
        end
        mask      <= '0;
        frame_bad <= 1'b0;
      end else if (state == ST_CAPTURE) begin
        mask <= mask | cap_sel;
        case (cap_sel)
          4'b0001: slot_l <= dec[3:0];
          4'b0010: slot_m <= dec[3:0];
          4'b0100: slot_h <= dec[3:0];
          4'b1000: slot_t <= dec[0];
          default: ;
        endcase
        if (!dec[4]) frame_bad <= 1'b1;
        if (cap_sel == 4'b1000 && dec[3:0] > 4'd1) frame_bad <= 1'b1;
      end
    end
  end

  // Publishes a confirmed candidate that differs from what is already shown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      target_out <= 1'b0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (match_cnt == 4'(MATCH_FRAMES) &&
          (!locked || cand != {data_out, target_out})) begin
        data_out   <= cand[12:1];
        target_out <= cand[0];
        data_valid <= 1'b1;
        locked     <= 1'b1;
      end
    end
  end

endmodule
